ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte to the keyboard (e.g. 0xED LED set, 0xF4 enable, 0xFF reset) over the same SCL/SDA pair the PS/2 receiver listens on.
- Performs clock inhibit and request-to-send, then shifts the start bit, 8 data bits LSB first, odd parity and stop bit on device-generated clocks, and checks the device ACK.
- Drives the lines open-drain through drive-low enables. Top level builds the tri-states.

---
 rtl/ps2_host_tx.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, then start/data/parity/stop on
// device clocks with ACK check. Optional build macro PS2_TX_RETRY_EN enables up to two retries.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES   = 6000,
    parameter int REQ_SETUP_CYCLES = 16,
    parameter int START_TIMEOUT    = 750000,
    parameter int BIT_TIMEOUT      = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    input  logic       SDA,
    output logic       scl_drive_low,
    output logic       sda_drive_low,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code
);

    localparam int MAX_PHASE = (INHIBIT_CYCLES > REQ_SETUP_CYCLES) ? INHIBIT_CYCLES : REQ_SETUP_CYCLES;
    localparam int MAX_TO    = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int MAX_CNT   = (MAX_PHASE > MAX_TO) ? MAX_PHASE : MAX_TO;
    localparam int CNT_W     = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST   = CNT_W'(REQ_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_RETRY
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       edge_q, edge_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic             scl_low_q, scl_low_d;
    logic             sda_low_q, sda_low_d;
    logic [1:0]       err_q, err_d;
    logic             error_q, error_d;
    logic             timeout;
    logic             finish;

`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    // Line synchronisers; idle-high reset values keep a spurious falling edge out of reset.
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       scl_s;
    logic       sda_s;
    logic       fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], SCL};
            sda_sync <= {sda_sync[0], SDA};
            scl_prev <= scl_sync[1];
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
    assign fall  = scl_prev & ~scl_s;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        edge_d    = edge_q;
        data_d    = data_q;
        parity_d  = parity_q;
        scl_low_d = scl_low_q;
        sda_low_d = sda_low_q;
        err_d     = err_q;
        error_d   = error_q;
        timeout   = 1'b0;
        finish    = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (tx_start) begin
                    data_d    = tx_data;
                    parity_d  = ~^tx_data;
                    err_d     = ERR_OK;
                    error_d   = 1'b0;
                    scl_low_d = 1'b1;
                    sda_low_d = 1'b0;
                    state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = 2'd0;
`endif
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    sda_low_d = 1'b1;
                    state_d   = S_REQ;
                end
            end

            S_REQ: begin
                if (cnt_q == REQ_LAST) begin
                    cnt_d     = '0;
                    edge_d    = 4'd0;
                    scl_low_d = 1'b0;
                    state_d   = S_SHIFT;
                end
            end

            // edge_q holds the edges seen so far, so edge n drives data bit n-1 = data_q[edge_q].
            S_SHIFT: begin
                if (fall) begin
                    cnt_d  = '0;
                    edge_d = edge_q + 4'd1;
                    if (edge_q == 4'd9) begin
                        sda_low_d = 1'b0;
                        state_d   = S_ACK;
                    end else if (edge_q == 4'd8) begin
                        sda_low_d = ~parity_q;
                    end else begin
                        sda_low_d = ~data_q[edge_q[2:0]];
                    end
                end else if (cnt_q == ((edge_q == 4'd0) ? START_LAST : BIT_LAST)) begin
                    timeout = 1'b1;
                end
            end

            S_ACK: begin
                if (fall) begin
                    cnt_d   = '0;
                    edge_d  = edge_q + 4'd1;
                    state_d = S_WAIT_IDLE;
                    if (sda_s) begin
                        err_d = ERR_NACK;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    timeout = 1'b1;
                end
            end

            S_WAIT_IDLE: begin
                if (scl_s && sda_s) begin
                    finish = 1'b1;
                end else if (cnt_q == BIT_LAST) begin
                    timeout = 1'b1;
                end
            end

            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end

`ifdef PS2_TX_RETRY_EN
            // Lines stay released for one inhibit period before the frame restarts.
            S_RETRY: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    err_d     = ERR_OK;
                    scl_low_d = 1'b1;
                    sda_low_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
`endif

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (timeout) begin
            scl_low_d = 1'b0;
            sda_low_d = 1'b0;
            err_d     = ERR_TIMEOUT;
            finish    = 1'b1;
        end

        if (finish) begin
            cnt_d   = '0;
            state_d = S_DONE;
            error_d = (err_d != ERR_OK);
`ifdef PS2_TX_RETRY_EN
            if ((err_d != ERR_OK) && (retry_q != 2'd2)) begin
                state_d   = S_RETRY;
                error_d   = error_q;
                retry_d   = retry_q + 2'd1;
                scl_low_d = 1'b0;
                sda_low_d = 1'b0;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= 4'd0;
            data_q    <= 8'h00;
            parity_q  <= 1'b0;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
            err_q     <= ERR_OK;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
            err_q     <= err_d;
            error_q   <= error_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q <= 2'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign scl_drive_low = scl_low_q;
    assign sda_drive_low = sda_low_q;
    assign tx_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign tx_done       = (state_q == S_DONE);
    assign tx_error      = error_q;
    assign err_code      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain line model, clocking keyboard model and a
// scoreboard of expected line bits and completion codes. Retry scenarios run under PS2_TX_RETRY_EN.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH    = 20;
    localparam int REQ    = 4;
    localparam int ST_TO  = 500;
    localparam int BIT_TO = 200;
    localparam int HALF   = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_scl_high = 1'b1;
    logic       dev_sda_low = 1'b0;
    logic       scl_line;
    logic       sda_line;
    logic       scl_drive_low;
    logic       sda_drive_low;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] err_code;

    int total = 0;
    int bad = 0;
    int done_count = 0;
    int inhibit_count = 0;
    int dev_edges = 0;
    logic scl_dl_prev = 1'b0;

    logic       exp_bits[$];
    logic       obs_bits[$];
    logic [1:0] exp_err[$];

    logic       snap_error;
    logic       snap_busy;
    logic       snap_scl;
    logic       snap_sda;
    logic [1:0] snap_err;

    assign scl_line = ~scl_drive_low & dev_scl_high;
    assign sda_line = ~sda_drive_low & ~dev_sda_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES  (INH),
        .REQ_SETUP_CYCLES(REQ),
        .START_TIMEOUT   (ST_TO),
        .BIT_TIMEOUT     (BIT_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .SCL          (scl_line),
        .SDA          (sda_line),
        .scl_drive_low(scl_drive_low),
        .sda_drive_low(sda_drive_low),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_error     (tx_error),
        .err_code     (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_count++;
        if (scl_drive_low === 1'b1 && scl_dl_prev !== 1'b1) inhibit_count++;
        scl_dl_prev = scl_drive_low;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Expected line values after edges 1..10: data LSB first, odd parity, released stop bit.
    function automatic void push_frame(input logic [7:0] d);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        exp_bits.push_back(($countones(d) % 2) == 0);
        exp_bits.push_back(1'b1);
    endfunction

    function automatic logic [29:0] pop_exp(input int n);
        logic [29:0] v = '0;
        for (int i = 0; i < n; i++) begin
            if (exp_bits.size() != 0) v[i] = exp_bits.pop_front();
            else v[i] = 1'bx;
        end
        return v;
    endfunction

    function automatic logic [29:0] pop_obs(input int n);
        logic [29:0] v = '0;
        for (int i = 0; i < n; i++) begin
            if (obs_bits.size() != 0) v[i] = obs_bits.pop_front();
            else v[i] = 1'bx;
        end
        return v;
    endfunction

    task automatic clear_queues();
        exp_bits.delete();
        obs_bits.delete();
        exp_err.delete();
    endtask

    task automatic send_start(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_release(output bit ok);
        int n = 0;
        while (!(scl_drive_low === 1'b0 && sda_drive_low === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 3000);
    endtask

    task automatic wait_done(input int limit, output bit seen, output int cycles);
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (tx_done === 1'b1) begin
                seen       = 1'b1;
                snap_err   = err_code;
                snap_error = tx_error;
                snap_busy  = tx_busy;
                snap_scl   = scl_drive_low;
                snap_sda   = sda_drive_low;
            end
        end
    endtask

    // Keyboard model: waits for request-to-send, clocks `edges` falling edges with a 60-clk period,
    // records SDA in each high phase and, if ack, pulls SDA low across edge 11.
    task automatic device(input int edges, input bit ack, output bit started);
        dev_edges = 0;
        wait_release(started);
        if (!started) return;
        repeat (10) @(negedge clk);
        for (int e = 1; e <= edges; e++) begin
            dev_scl_high = 1'b0;
            dev_edges = e;
            repeat (HALF) @(negedge clk);
            dev_scl_high = 1'b1;
            if (e == 11) dev_sda_low = 1'b0;
            repeat (8) @(negedge clk);
            if (e <= 10) obs_bits.push_back(sda_line);
            if (e == 10 && ack) dev_sda_low = 1'b1;
            repeat (HALF - 8) @(negedge clk);
        end
        dev_sda_low = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({scl_drive_low, sda_drive_low, tx_busy, tx_done, tx_error, err_code} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {scl_drive_low, sda_drive_low, tx_busy, tx_done, tx_error, err_code});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (tx_busy !== 1'b0 || scl_drive_low !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b scl_low=%b want 0 0", tx_busy, scl_drive_low);
        end
    endtask

    task automatic test_normal_ed();
        int inh, req, cyc, base;
        bit started, seen;
        logic [29:0] eb, ob;
        logic [1:0] ee;
        clear_queues();
        push_frame(8'hED);
        exp_err.push_back(2'b00);
        base = done_count;
        send_start(8'hED);
        total++;
        if (tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL ed_busy_after_accept: got %b want 1", tx_busy);
        end
        fork
            device(11, 1'b1, started);
            begin
                inh = 0;
                while (scl_drive_low === 1'b1 && sda_drive_low === 1'b0 && inh < 1000) begin
                    inh++;
                    @(negedge clk);
                end
                req = 0;
                while (scl_drive_low === 1'b1 && sda_drive_low === 1'b1 && req < 1000) begin
                    req++;
                    @(negedge clk);
                end
                wait_done(2000, seen, cyc);
            end
        join
        repeat (5) @(negedge clk);
        total++;
        if (inh != INH) begin bad++; $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH); end
        total++;
        if (req != REQ) begin bad++; $display("FAIL ed_req_len: got %0d want %0d", req, REQ); end
        total++;
        if (!started || !seen) begin bad++; $display("FAIL ed_done_seen: got %0d%0d want 11", started, seen); end
        eb = pop_exp(10);
        ob = pop_obs(10);
        total++;
        if (ob !== eb) begin bad++; $display("FAIL ed_bits: got %b want %b", ob[9:0], eb[9:0]); end
        ee = exp_err.pop_front();
        total++;
        if ({snap_err, snap_error, snap_busy} !== {ee, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ed_status: got err=%b error=%b busy=%b want err=%b error=0 busy=0",
                     snap_err, snap_error, snap_busy, ee);
        end
        total++;
        if (done_count - base != 1) begin bad++; $display("FAIL ed_done_pulses: got %0d want 1", done_count - base); end
    endtask

    task automatic test_normal_f4();
        int n, cyc, base;
        bit started, seen;
        logic [29:0] eb, ob;
        logic [1:0] ee;
        clear_queues();
        push_frame(8'hF4);
        exp_err.push_back(2'b00);
        base = done_count;
        dev_edges = 0;
        send_start(8'hF4);
        fork
            device(11, 1'b1, started);
            begin
                n = 0;
                while (dev_edges < 3 && n < 3000) begin @(negedge clk); n++; end
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                wait_done(2000, seen, cyc);
            end
        join
        repeat (50) @(negedge clk);
        eb = pop_exp(10);
        ob = pop_obs(10);
        total++;
        if (ob !== eb) begin bad++; $display("FAIL f4_bits: got %b want %b", ob[9:0], eb[9:0]); end
        ee = exp_err.pop_front();
        total++;
        if (!seen || snap_err !== ee || snap_error !== 1'b0) begin
            bad++;
            $display("FAIL f4_status: got seen=%0d err=%b error=%b want seen=1 err=%b error=0",
                     seen, snap_err, snap_error, ee);
        end
        total++;
        if (done_count - base != 1 || tx_busy !== 1'b0) begin
            bad++;
            $display("FAIL f4_ignore_start: got done=%0d busy=%b want 1 0", done_count - base, tx_busy);
        end
    endtask

`ifndef PS2_TX_RETRY_EN
    task automatic test_no_ack();
        int cyc;
        bit started, seen;
        logic [29:0] eb, ob;
        logic [1:0] ee;
        clear_queues();
        push_frame(8'hED);
        exp_err.push_back(2'b10);
        send_start(8'hED);
        fork
            device(11, 1'b0, started);
            wait_done(2000, seen, cyc);
        join
        eb = pop_exp(10);
        ob = pop_obs(10);
        total++;
        if (ob !== eb) begin bad++; $display("FAIL nack_bits: got %b want %b", ob[9:0], eb[9:0]); end
        ee = exp_err.pop_front();
        total++;
        if (!seen || {snap_err, snap_error, snap_scl, snap_sda} !== {ee, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL nack_status: got seen=%0d err=%b error=%b scl=%b sda=%b want err=%b error=1 lines=00",
                     seen, snap_err, snap_error, snap_scl, snap_sda, ee);
        end
        repeat (5) @(negedge clk);
        total++;
        if (tx_error !== 1'b1 || err_code !== 2'b10) begin
            bad++;
            $display("FAIL nack_hold: got error=%b err=%b want 1 10", tx_error, err_code);
        end
    endtask

    task automatic test_dead_device();
        int cyc;
        bit ok, seen;
        logic [1:0] ee;
        clear_queues();
        exp_err.push_back(2'b01);
        send_start(8'hFF);
        wait_release(ok);
        wait_done(2000, seen, cyc);
        ee = exp_err.pop_front();
        total++;
        if (!ok || !seen || cyc != ST_TO) begin
            bad++;
            $display("FAIL dead_timeout_len: got %0d cycles (release=%0d done=%0d) want %0d", cyc, ok, seen, ST_TO);
        end
        total++;
        if ({snap_err, snap_error, snap_scl, snap_sda, snap_busy} !== {ee, 1'b1, 3'b000}) begin
            bad++;
            $display("FAIL dead_status: got err=%b error=%b scl=%b sda=%b busy=%b want err=%b error=1 rest=0",
                     snap_err, snap_error, snap_scl, snap_sda, snap_busy, ee);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_stall_timeout();
        int n, cyc;
        bit started, seen;
        logic [1:0] ee;
        clear_queues();
        exp_err.push_back(2'b01);
        dev_edges = 0;
        send_start(8'hF4);
        fork
            device(4, 1'b0, started);
            begin
                n = 0;
                while (dev_edges < 4 && n < 3000) begin @(negedge clk); n++; end
                wait_done(1000, seen, cyc);
            end
        join
        ee = exp_err.pop_front();
        total++;
        if (!seen || cyc < BIT_TO || cyc > BIT_TO + 6) begin
            bad++;
            $display("FAIL stall_timeout_len: got %0d cycles (done=%0d) want %0d..%0d", cyc, seen, BIT_TO, BIT_TO + 6);
        end
        total++;
        if ({snap_err, snap_error, snap_scl, snap_sda} !== {ee, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL stall_status: got err=%b error=%b scl=%b sda=%b want err=%b error=1 lines=00",
                     snap_err, snap_error, snap_scl, snap_sda, ee);
        end
        obs_bits.delete();
        repeat (5) @(negedge clk);
    endtask
`endif

`ifdef PS2_TX_RETRY_EN
    task automatic test_retry_recover();
        int cyc, base_done, base_inh;
        bit s1, s2, s3, seen;
        logic [29:0] eb, ob;
        logic [1:0] ee;
        clear_queues();
        for (int i = 0; i < 3; i++) push_frame(8'hED);
        exp_err.push_back(2'b00);
        base_done = done_count;
        base_inh  = inhibit_count;
        send_start(8'hED);
        fork
            begin
                device(11, 1'b0, s1);
                device(11, 1'b0, s2);
                device(11, 1'b1, s3);
            end
            wait_done(6000, seen, cyc);
        join
        repeat (20) @(negedge clk);
        eb = pop_exp(30);
        ob = pop_obs(30);
        total++;
        if (ob !== eb) begin bad++; $display("FAIL retry_ok_bits: got %b want %b", ob, eb); end
        ee = exp_err.pop_front();
        total++;
        if (!seen || snap_err !== ee || snap_error !== 1'b0) begin
            bad++;
            $display("FAIL retry_ok_status: got seen=%0d err=%b error=%b want err=%b error=0", seen, snap_err, snap_error, ee);
        end
        total++;
        if (done_count - base_done != 1 || inhibit_count - base_inh != 3) begin
            bad++;
            $display("FAIL retry_ok_counts: got done=%0d inhibit=%0d want 1 3", done_count - base_done, inhibit_count - base_inh);
        end
    endtask

    task automatic test_retry_fail();
        int cyc, base_done, base_inh;
        bit s1, s2, s3, seen;
        logic [1:0] ee;
        clear_queues();
        exp_err.push_back(2'b10);
        base_done = done_count;
        base_inh  = inhibit_count;
        send_start(8'hF4);
        fork
            begin
                device(11, 1'b0, s1);
                device(11, 1'b0, s2);
                device(11, 1'b0, s3);
            end
            wait_done(6000, seen, cyc);
        join
        repeat (20) @(negedge clk);
        ee = exp_err.pop_front();
        total++;
        if (!seen || snap_err !== ee || snap_error !== 1'b1) begin
            bad++;
            $display("FAIL retry_fail_status: got seen=%0d err=%b error=%b want err=%b error=1", seen, snap_err, snap_error, ee);
        end
        total++;
        if (done_count - base_done != 1 || inhibit_count - base_inh != 3) begin
            bad++;
            $display("FAIL retry_fail_counts: got done=%0d inhibit=%0d want 1 3", done_count - base_done, inhibit_count - base_inh);
        end
        obs_bits.delete();
    endtask
`endif

    task automatic test_reset_mid_frame();
        int n, cyc, base;
        bit started, seen;
        logic [29:0] eb, ob;
        logic [1:0] ee;
        clear_queues();
        base = done_count;
        dev_edges = 0;
        send_start(8'h5A);
        fork
            device(5, 1'b0, started);
            begin
                n = 0;
                while (dev_edges < 5 && n < 3000) begin @(negedge clk); n++; end
                repeat (6) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                total++;
                if ({scl_drive_low, sda_drive_low, tx_busy} !== 3'b000) begin
                    bad++;
                    $display("FAIL midreset_outputs: got %b want 000", {scl_drive_low, sda_drive_low, tx_busy});
                end
                rst = 1'b0;
            end
        join
        repeat (300) @(negedge clk);
        total++;
        if (done_count - base != 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", done_count - base); end

        clear_queues();
        push_frame(8'hFF);
        exp_err.push_back(2'b00);
        send_start(8'hFF);
        fork
            device(11, 1'b1, started);
            wait_done(2000, seen, cyc);
        join
        eb = pop_exp(10);
        ob = pop_obs(10);
        total++;
        if (ob !== eb) begin bad++; $display("FAIL ff_bits: got %b want %b", ob[9:0], eb[9:0]); end
        ee = exp_err.pop_front();
        total++;
        if (!seen || snap_err !== ee || snap_error !== 1'b0) begin
            bad++;
            $display("FAIL ff_status: got seen=%0d err=%b error=%b want err=%b error=0", seen, snap_err, snap_error, ee);
        end
    endtask

    initial begin
        test_reset();
        test_normal_ed();
        test_normal_f4();
`ifdef PS2_TX_RETRY_EN
        test_retry_recover();
        test_retry_fail();
`else
        test_no_ack();
        test_dead_device();
        test_stall_timeout();
`endif
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
